// File: rtl/cdb_rr_arbiter_pkg.sv
// Shared types for the Common Data Bus: result payload, requester indices and sizing constants.
package cdb_rr_arbiter_pkg;

  localparam int unsigned N_CDB_REQ = 4;
  localparam int unsigned CDB_TAG_W = 6;

  typedef enum logic [1:0] {
    REQ_INT = 2'd0,
    REQ_MUL = 2'd1,
    REQ_DIV = 2'd2,
    REQ_LS  = 2'd3
  } cdb_req_e;

  typedef struct packed {
    logic [31:0]          data;
    logic [CDB_TAG_W-1:0] tag;
    logic                 valid;
    logic                 branch;
    logic                 branch_taken;
  } cdb_bus_t;

endpackage

// File: rtl/cdb_rr_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping modulo N_REQ.
module cdb_rr_arbiter_rr #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx
);

  logic        found;
  int unsigned sel;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    sel   = 0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      sel = (32'(ptr) + off) % N_REQ;
      if (!found && req[sel]) begin
        found      = 1'b1;
        grant[sel] = 1'b1;
        idx        = IDX_W'(sel);
      end
    end
  end

endmodule

// File: rtl/cdb_rr_arbiter.sv
// Common Data Bus arbiter: one holding slot per unit, round-robin grant, registered broadcast.
// Optional per-unit grant/stall counters are enabled by defining CDB_PERF_CNT_EN.
module cdb_rr_arbiter
  import cdb_rr_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = N_CDB_REQ,
  parameter int unsigned TAG_W = CDB_TAG_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [N_REQ-1:0]         req_valid,
  input  cdb_bus_t                 req_cdb [N_REQ],
  output logic [N_REQ-1:0]         req_ready,
  output cdb_bus_t                 cdb_out,
  output logic [$clog2(N_REQ)-1:0] cdb_src,
  output logic                     cdb_busy
`ifdef CDB_PERF_CNT_EN
  ,
  output logic [31:0]              perf_grants [N_REQ],
  output logic [31:0]              perf_stall  [N_REQ]
`endif
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  if (TAG_W != CDB_TAG_W) begin : g_tag_w_mismatch
    $error("TAG_W must equal the cdb_bus tag width");
  end

  cdb_bus_t         slot_q [N_REQ];
  logic [N_REQ-1:0] slot_full_q;
  logic [IdxW-1:0]  ptr_q;
  logic [N_REQ-1:0] grant;
  logic [IdxW-1:0]  grant_idx;
  logic [N_REQ-1:0] handshake;
  logic             any_full;

  cdb_rr_arbiter_rr #(
    .N_REQ (N_REQ),
    .IDX_W (IdxW)
  ) u_rr (
    .req   (slot_full_q),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (grant_idx)
  );

  // A slot being drained this cycle can be refilled at the same edge.
  assign req_ready = {N_REQ{!flush}} & (~slot_full_q | grant);
  assign handshake = req_valid & req_ready;
  assign any_full  = |slot_full_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) slot_q[i] <= '0;
      slot_full_q <= '0;
      ptr_q       <= '0;
      cdb_out     <= '0;
      cdb_src     <= '0;
      cdb_busy    <= 1'b0;
    end else if (flush) begin
      slot_full_q <= '0;
      cdb_out     <= '0;
      cdb_busy    <= 1'b0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (handshake[i]) begin
          slot_q[i]      <= req_cdb[i];
          slot_full_q[i] <= 1'b1;
        end else if (grant[i]) begin
          slot_full_q[i] <= 1'b0;
        end
      end
      if (any_full) begin
        cdb_out  <= slot_q[grant_idx];
        cdb_src  <= grant_idx;
        cdb_busy <= 1'b1;
        ptr_q    <= (grant_idx == IdxW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end else begin
        cdb_out  <= '0;
        cdb_busy <= 1'b0;
      end
    end
  end

`ifdef CDB_PERF_CNT_EN
  // Counters survive flush; a grant suppressed by flush is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        perf_grants[i] <= '0;
        perf_stall[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant[i] && !flush) perf_grants[i] <= perf_grants[i] + 32'd1;
        if (req_valid[i] && !req_ready[i]) perf_stall[i] <= perf_stall[i] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Directed self-checking bench for cdb_rr_arbiter with hand-computed expectations.
module tb_cdb_rr_arbiter;
  import cdb_rr_arbiter_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [3:0] req_valid;
  cdb_bus_t   req_cdb [N_CDB_REQ];
  logic [3:0] req_ready;
  cdb_bus_t   cdb_out;
  logic [1:0] cdb_src;
  logic       cdb_busy;
`ifdef CDB_PERF_CNT_EN
  logic [31:0] perf_grants [N_CDB_REQ];
  logic [31:0] perf_stall  [N_CDB_REQ];
`endif

  int tests;
  int failed;

  cdb_rr_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_cdb   (req_cdb),
    .req_ready (req_ready),
    .cdb_out   (cdb_out),
    .cdb_src   (cdb_src),
    .cdb_busy  (cdb_busy)
`ifdef CDB_PERF_CNT_EN
    ,
    .perf_grants (perf_grants),
    .perf_stall  (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic cdb_bus_t mk(input logic [5:0] tag, input logic [31:0] data,
                                  input logic v, input logic br, input logic tk);
    cdb_bus_t c;
    c.data         = data;
    c.tag          = tag;
    c.valid        = v;
    c.branch       = br;
    c.branch_taken = tk;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return at the falling edge so outputs are stable.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input int i, input cdb_bus_t c);
    req_valid[i] = 1'b1;
    req_cdb[i]   = c;
  endtask

  task automatic chk_bcast(input string tag, input cdb_bus_t exp, input logic [1:0] src);
    chk({tag, ".out"}, 64'(cdb_out), 64'(exp));
    chk({tag, ".src"}, 64'(cdb_src), 64'(src));
    chk({tag, ".busy"}, 64'(cdb_busy), 64'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".out"}, 64'(cdb_out), 64'd0);
    chk({tag, ".busy"}, 64'(cdb_busy), 64'd0);
  endtask

  initial begin
    tests     = 0;
    failed    = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    req_valid = '0;
    for (int i = 0; i < 4; i++) req_cdb[i] = '0;

    // Reset state
    #1;
    chk_idle("rst");
    chk("rst.ready", 64'(req_ready), 64'hf);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Single int request: broadcast after E1, idle afterwards; ptr -> 1
    drive(REQ_INT, mk(6'h05, 32'h1234, 1'b1, 1'b0, 1'b0));
    cyc();
    req_valid = '0;
    chk("single.e0busy", 64'(cdb_busy), 64'd0);
    cyc();
    chk_bcast("single", mk(6'h05, 32'h1234, 1'b1, 1'b0, 1'b0), 2'd0);
    cyc();
    chk_idle("single.after");

    // Unit 3 alone wins from ptr=1; ptr wraps to 0
    drive(REQ_LS, mk(6'h33, 32'h3333, 1'b1, 1'b0, 1'b0));
    cyc();
    req_valid = '0;
    cyc();
    chk_bcast("wrap", mk(6'h33, 32'h3333, 1'b1, 1'b0, 1'b0), 2'd3);
    cyc();

    // Contention from ptr=0; unit 0 refilled on its drain cycle, served after unit 3
    for (int i = 0; i < 4; i++) drive(i, mk(6'(8'h10 + i), 32'(32'hA0 + i), 1'b1, 1'b0, 1'b0));
    cyc();
    req_valid = '0;
    #1;
    chk("cont.ready", 64'(req_ready), 64'h1);
    drive(REQ_INT, mk(6'h14, 32'hA4, 1'b1, 1'b0, 1'b0));
    cyc();
    req_valid = '0;
    chk_bcast("cont0", mk(6'h10, 32'hA0, 1'b1, 1'b0, 1'b0), 2'd0);
    cyc();
    chk_bcast("cont1", mk(6'h11, 32'hA1, 1'b1, 1'b0, 1'b0), 2'd1);
    cyc();
    chk_bcast("cont2", mk(6'h12, 32'hA2, 1'b1, 1'b0, 1'b0), 2'd2);
    cyc();
    chk_bcast("cont3", mk(6'h13, 32'hA3, 1'b1, 1'b0, 1'b0), 2'd3);
    cyc();
    chk_bcast("cont0r", mk(6'h14, 32'hA4, 1'b1, 1'b0, 1'b0), 2'd0);
    cyc();
    chk_idle("cont.after");

    // Back-to-back int results: no bubble, ready stays high
    for (int k = 0; k < 7; k++) begin
      if (k >= 2)
        chk_bcast("b2b", mk(6'(8'h20 + k - 2), 32'(k - 2), 1'b1, 1'b0, 1'b0), 2'd0);
      if (k < 5) begin
        drive(REQ_INT, mk(6'(8'h20 + k), 32'(k), 1'b1, 1'b0, 1'b0));
        #1;
        chk("b2b.ready", 64'(req_ready[0]), 64'd1);
      end else begin
        req_valid = '0;
      end
      cyc();
    end
    chk_idle("b2b.after");

    // Branch result is arbitrated like any other
    drive(REQ_INT, mk(6'h2A, 32'hBEEF, 1'b0, 1'b1, 1'b1));
    cyc();
    req_valid = '0;
    cyc();
    chk_bcast("branch", mk(6'h2A, 32'hBEEF, 1'b0, 1'b1, 1'b1), 2'd0);
    cyc();

    // Flush with three full slots; ptr=1 so unit 1 is on the bus when flush hits
    for (int i = 1; i < 4; i++) drive(i, mk(6'(8'h30 + i), 32'(32'hC0 + i), 1'b1, 1'b0, 1'b0));
    cyc();
    req_valid = '0;
    cyc();
    chk_bcast("preflush", mk(6'h31, 32'hC1, 1'b1, 1'b0, 1'b0), 2'd1);
    flush = 1'b1;
    drive(REQ_INT, mk(6'h3F, 32'hDEAD, 1'b1, 1'b0, 1'b0));
    #1;
    chk("flush.ready", 64'(req_ready), 64'h0);
    cyc();
    flush     = 1'b0;
    req_valid = '0;
    chk_idle("flush");
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk_idle("flush.stale");
    end

    // ptr survives flush (=2): all four request, unit 2 goes first
    for (int i = 0; i < 4; i++) drive(i, mk(6'(8'h38 + i), 32'(32'hE0 + i), 1'b1, 1'b0, 1'b0));
    cyc();
    req_valid = '0;
    cyc();
    chk_bcast("ptrkeep", mk(6'h3A, 32'hE2, 1'b1, 1'b0, 1'b0), 2'd2);

    // Asynchronous reset mid-traffic: outputs clear before any clock edge
    #1;
    rst_n = 1'b0;
    #1;
    chk_idle("arst");
    chk("arst.ready", 64'(req_ready), 64'hf);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk_idle("arst.discard");

    // ptr back at 0: units 1 and 3 pending, unit 1 first
    drive(REQ_MUL, mk(6'h01, 32'h51, 1'b1, 1'b0, 1'b0));
    drive(REQ_LS, mk(6'h03, 32'h53, 1'b1, 1'b0, 1'b0));
    cyc();
    req_valid = '0;
    cyc();
    chk_bcast("arst.ptr1", mk(6'h01, 32'h51, 1'b1, 1'b0, 1'b0), 2'd1);
    cyc();
    chk_bcast("arst.ptr3", mk(6'h03, 32'h53, 1'b1, 1'b0, 1'b0), 2'd3);
    cyc();
    chk_idle("end");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
